beta_irq_ctrl: RTL and testbench

- Parametrised, memory-mapped interrupt controller that widens the Beta's single irq input into NUM_IRQ external request lines.
- Per channel: input synchronisation, edge or level mode, pending/enable registers and a fixed-priority claim register.
- Sits on the Beta data bus beside data memory. Its IrqOut drives the CPU irq pin.
- The top-level ORs its DataRead into the CPU read path, qualified by Hit.

---
 rtl/beta_irq_pkg.sv | 26 ++
 rtl/beta_sync.sv | 46 ++++
 rtl/beta_irq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_beta_irq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_irq_pkg.sv
// -----------------------------------------------------------------------------
// beta_irq_pkg
//   Shared definitions for the Beta interrupt controller: register word
//   offsets inside the 32-byte window, channel limits and claim-value width.
// -----------------------------------------------------------------------------
package beta_irq_pkg;

    // Upper bound on the number of request channels the register map can hold.
    localparam int MAX_IRQ = 32;

    // CLAIM returns 0..MAX_IRQ, so it needs one bit more than log2(MAX_IRQ).
    localparam int CLAIM_W = $clog2(MAX_IRQ + 1);

    // Word index of each register (DataAddress[4:2]).
    typedef enum logic [2:0] {
        OFF_PENDING = 3'd0,
        OFF_ENABLE  = 3'd1,
        OFF_MODE    = 3'd2,
        OFF_CLAIM   = 3'd3,
        OFF_RAW     = 3'd4,
        OFF_RSVD5   = 3'd5,
        OFF_RSVD6   = 3'd6,
        OFF_RSVD7   = 3'd7
    } reg_off_e;

endpackage : beta_irq_pkg

// File: rtl/beta_sync.sv
// -----------------------------------------------------------------------------
// beta_sync
//   Multi-flop synchroniser bank: each of WIDTH bits passes through a chain of
//   STAGES flops clocked by clk, giving a metastability-filtered copy of an
//   asynchronous input bus.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, clears every stage
//   d_i    in   [WIDTH-1:0] asynchronous inputs
//   q_o    out  [WIDTH-1:0] synchronised outputs (last stage)
// -----------------------------------------------------------------------------
module beta_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    // NOTE: every stage is reset, not just the last. This array is a flop
    // chain rather than a RAM, and leaving early stages at X would let stale
    // values ripple out for STAGES-1 cycles after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                chain_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value; blocking ones would collapse the chain
            // into a single flop.
            chain_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule : beta_sync

// File: rtl/beta_irq_ctrl.sv
// -----------------------------------------------------------------------------
// beta_irq_ctrl
//   Memory-mapped interrupt controller that fans the Beta's single irq input
//   out to NUM_IRQ external request lines. Each channel is synchronised, then
//   latched as edge- or level-triggered into PENDING; PENDING & ENABLE form the
//   active set, whose OR drives the CPU irq pin through one register. A CLAIM
//   read returns the lowest-numbered active channel (index+1, 0 if none) and
//   acknowledges it if that channel is edge-triggered.
//
// Register window (32 bytes at BASE_ADDR, word offsets):
//   0x00 PENDING  R, write-1-to-clear (edge channels only)
//   0x04 ENABLE   RW
//   0x08 MODE     RW, 1 = edge, 0 = level
//   0x0C CLAIM    R, reading acknowledges the claimed edge channel
//   0x10 RAW      R, synchronised inputs
//   0x14-0x1C     read 0, writes ignored
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   IrqIn        in   [NUM_IRQ-1:0] raw asynchronous request lines
//   DataAddress  in   [31:0] CPU byte address
//   DataWrite    in   [31:0] CPU store data
//   WriteEnable  in   CPU store strobe
//   ReadEnable   in   CPU load strobe
//   DataRead     out  [31:0] combinational read data, 0 when Hit is low
//   Hit          out  access falls inside this window
//   IrqOut       out  registered interrupt request to the CPU
// -----------------------------------------------------------------------------
module beta_irq_ctrl
    import beta_irq_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] IrqIn,
    input  logic [31:0]        DataAddress,
    input  logic [31:0]        DataWrite,
    input  logic               WriteEnable,
    input  logic               ReadEnable,
    output logic [31:0]        DataRead,
    output logic               Hit,
    output logic               IrqOut
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q,  enable_d;
    logic [NUM_IRQ-1:0] mode_q,    mode_d;
    logic               irq_out_q;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    reg_off_e           reg_off;
    logic               wr_en;
    logic               rd_en;
    logic [NUM_IRQ-1:0] wr_data;

    assign Hit     = (ReadEnable || WriteEnable) &&
                     (DataAddress[31:5] == BASE_ADDR[31:5]);
    assign reg_off = reg_off_e'(DataAddress[4:2]);
    assign wr_en   = Hit && WriteEnable;
    assign rd_en   = Hit && ReadEnable;
    assign wr_data = DataWrite[NUM_IRQ-1:0];

    // Byte-lane bits and data bits above NUM_IRQ carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{DataAddress[1:0], DataWrite};

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    beta_sync #(
        .WIDTH  (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (IrqIn),
        .q_o   (sync_s)
    );

    // -------------------------------------------------------------------------
    // Fixed-priority claim encoder: lowest-numbered active channel wins.
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] active;
    logic [CLAIM_W-1:0] claim_val;
    logic [NUM_IRQ-1:0] claim_onehot;

    assign active = pending_q & enable_q;

    // NOTE: both outputs get a default before the loop so that every path
    // assigns them; without it this always_comb would infer latches.
    always_comb begin
        claim_val    = '0;
        claim_onehot = '0;
        // Scanning downward lets the lowest set index overwrite the others.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_val       = CLAIM_W'(i + 1);
                claim_onehot    = '0;
                claim_onehot[i] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] set_edge;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] mode_chg;

    assign set_edge = sync_s & ~prev_q;

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        clr      = '0;
        mode_chg = '0;

        if (wr_en) begin
            case (reg_off)
                OFF_PENDING: clr = wr_data;
                OFF_ENABLE:  enable_d = wr_data;
                OFF_MODE: begin
                    mode_d   = wr_data;
                    mode_chg = mode_q ^ wr_data;
                end
                default: ;
            endcase
        end

        // A CLAIM read acknowledges the channel it reports.
        if (rd_en && (reg_off == OFF_CLAIM)) begin
            clr = clr | claim_onehot;
        end

        // Edge channels: a new edge beats a same-cycle clear. Level channels
        // simply track the synchronised input and ignore clears.
        pending_d = (mode_q  & (set_edge | (pending_q & ~clr)))
                  | (~mode_q & sync_s);

        // Switching a channel's mode discards whatever it had pending; a
        // level channel picks its input back up on the following cycle.
        pending_d = pending_d & ~mode_chg;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            irq_out_q <= 1'b0;
        end else begin
            prev_q    <= sync_s;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            irq_out_q <= |active;
        end
    end

    assign IrqOut = irq_out_q;

    // -------------------------------------------------------------------------
    // Read mux: reflects current state, so a simultaneous write is not yet
    // visible and a CLAIM read shows the channel being acknowledged.
    // -------------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (Hit) begin
            case (reg_off)
                OFF_PENDING: rd_val[NUM_IRQ-1:0] = pending_q;
                OFF_ENABLE:  rd_val[NUM_IRQ-1:0] = enable_q;
                OFF_MODE:    rd_val[NUM_IRQ-1:0] = mode_q;
                OFF_CLAIM:   rd_val[CLAIM_W-1:0] = claim_val;
                OFF_RAW:     rd_val[NUM_IRQ-1:0] = sync_s;
                default:     rd_val = '0;
            endcase
        end
    end

    assign DataRead = rd_val;

endmodule : beta_irq_ctrl

// File: tb/tb_beta_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beta_irq_ctrl
//   Directed bench for beta_irq_ctrl (NUM_IRQ=8, SYNC_STAGES=2): a table of
//   bus decode vectors followed by hand-written multi-cycle sequences for
//   latency, priority, level mode, set/clear collision and async reset.
// -----------------------------------------------------------------------------
module tb_beta_irq_ctrl;
    import beta_irq_pkg::*;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'hFFFF_F000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [31:0]   rdata;
    logic          hit;
    logic          irq_out;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    beta_irq_ctrl #(
        .NUM_IRQ     (N),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IrqIn       (irq_in),
        .DataAddress (addr),
        .DataWrite   (wdata),
        .WriteEnable (we),
        .ReadEnable  (re),
        .DataRead    (rdata),
        .Hit         (hit),
        .IrqOut      (irq_out)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_addr(input int off);
        return BASE + 32'(off * 4);
    endfunction

    // Side-effect-free look at the read path, completed between edges.
    task automatic peek(input logic [31:0] a, output logic [31:0] d,
                        output logic h);
        addr = a;
        re   = 1'b1;
        #1;
        d    = rdata;
        h    = hit;
        re   = 1'b0;
    endtask

    task automatic expect_reg(input string name, input int off,
                              input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        peek(reg_addr(off), d, h);
        check(name, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // CLAIM read held across an edge so the acknowledge takes effect.
    task automatic claim_read(output logic [31:0] d);
        addr = reg_addr(OFF_CLAIM);
        re   = 1'b1;
        #1;
        d    = rdata;
        tick();
        re   = 1'b0;
    endtask

    // ---------------------------------------------------------- decode table
    typedef struct {
        logic [31:0] addr;
        logic        do_write;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        h;

        vecs[0]  = '{BASE + 32'h00, 1'b0, 32'h0,          1'b1, 32'h0000_0000};
        vecs[1]  = '{BASE + 32'h04, 1'b1, 32'hFFFF_FFFF,  1'b1, 32'h0000_00FF};
        vecs[2]  = '{BASE + 32'h08, 1'b1, 32'h1234_56A5,  1'b1, 32'h0000_00A5};
        vecs[3]  = '{BASE + 32'h05, 1'b0, 32'h0,          1'b1, 32'h0000_00FF};
        vecs[4]  = '{BASE + 32'h14, 1'b1, 32'hFFFF_FFFF,  1'b1, 32'h0000_0000};
        vecs[5]  = '{BASE + 32'h18, 1'b0, 32'h0,          1'b1, 32'h0000_0000};
        vecs[6]  = '{BASE + 32'h1C, 1'b1, 32'hFFFF_FFFF,  1'b1, 32'h0000_0000};
        vecs[7]  = '{BASE + 32'h10, 1'b1, 32'h0000_00FF,  1'b1, 32'h0000_0000};
        vecs[8]  = '{BASE + 32'h0C, 1'b1, 32'h0000_00FF,  1'b1, 32'h0000_0000};
        vecs[9]  = '{BASE + 32'h20, 1'b1, 32'h0000_0000,  1'b0, 32'h0000_0000};
        vecs[10] = '{BASE - 32'h04, 1'b0, 32'h0,          1'b0, 32'h0000_0000};
        vecs[11] = '{BASE + 32'h04, 1'b1, 32'h0000_0000,  1'b1, 32'h0000_0000};
        vecs[12] = '{BASE + 32'h08, 1'b1, 32'h0000_0000,  1'b1, 32'h0000_0000};

        // ------------------------------------------------------ power-on reset
        #3;
        check("por_irqout", 32'(irq_out), 32'h0);
        expect_reg("por_pending", OFF_PENDING, 32'h0);
        #20;
        rst = 1'b1;
        tick();
        expect_reg("por_enable", OFF_ENABLE, 32'h0);
        expect_reg("por_mode",   OFF_MODE,   32'h0);

        // ------------------------------------------------------- decode table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_write) bus_write(vecs[i].addr, vecs[i].wdata);
            peek(vecs[i].addr, d, h);
            check($sformatf("vec%0d_hit", i),  32'(h), 32'(vecs[i].exp_hit));
            check($sformatf("vec%0d_data", i), d,      vecs[i].exp_rdata);
        end

        // --------------------------------------------------------- edge latency
        bus_write(reg_addr(OFF_MODE),   32'hFF);
        bus_write(reg_addr(OFF_ENABLE), 32'h08);
        irq_in[3] = 1'b1;
        tick();                                   // edge k
        expect_reg("lat_k_pending", OFF_PENDING, 32'h00);
        tick();                                   // k+1
        expect_reg("lat_k1_raw",     OFF_RAW,     32'h08);
        expect_reg("lat_k1_pending", OFF_PENDING, 32'h00);
        tick();                                   // k+2
        expect_reg("lat_k2_pending", OFF_PENDING, 32'h08);
        check("lat_k2_irqout", 32'(irq_out), 32'h0);
        tick();                                   // k+3
        check("lat_k3_irqout", 32'(irq_out), 32'h1);
        claim_read(d);
        check("lat_claim", d, 32'd4);
        expect_reg("lat_after_claim_pending", OFF_PENDING, 32'h00);
        check("lat_after_claim_irqout", 32'(irq_out), 32'h1);
        tick();
        check("lat_irqout_drop", 32'(irq_out), 32'h0);
        irq_in[3] = 1'b0;
        repeat (3) tick();

        // ------------------------------------------------------------ priority
        bus_write(reg_addr(OFF_ENABLE), 32'hFF);
        irq_in = 8'h44;
        repeat (2) tick();
        irq_in = 8'h00;
        repeat (3) tick();
        expect_reg("prio_pending", OFF_PENDING, 32'h44);
        claim_read(d);
        check("prio_claim1", d, 32'd3);
        claim_read(d);
        check("prio_claim2", d, 32'd7);
        claim_read(d);
        check("prio_claim3", d, 32'd0);
        expect_reg("prio_pending_end", OFF_PENDING, 32'h00);

        // --------------------------------------------------------------- level
        bus_write(reg_addr(OFF_MODE),   32'h00);
        bus_write(reg_addr(OFF_ENABLE), 32'h01);
        irq_in[0] = 1'b1;
        repeat (3) tick();
        expect_reg("lvl_pending", OFF_PENDING, 32'h01);
        bus_write(reg_addr(OFF_PENDING), 32'h01);
        expect_reg("lvl_after_w1c", OFF_PENDING, 32'h01);
        check("lvl_irqout", 32'(irq_out), 32'h1);
        claim_read(d);
        check("lvl_claim", d, 32'd1);
        expect_reg("lvl_after_claim", OFF_PENDING, 32'h01);
        irq_in[0] = 1'b0;
        repeat (2) tick();
        expect_reg("lvl_hold", OFF_PENDING, 32'h01);
        tick();
        expect_reg("lvl_drop", OFF_PENDING, 32'h00);

        // ---------------------------------------------------- set/clear collide
        bus_write(reg_addr(OFF_MODE), 32'hFF);
        irq_in[1] = 1'b1;
        repeat (2) tick();                        // edges k, k+1
        bus_write(reg_addr(OFF_PENDING), 32'h02); // edge k+2: set and W1C
        expect_reg("coll_set_wins", OFF_PENDING, 32'h02);
        bus_write(reg_addr(OFF_PENDING), 32'h02);
        expect_reg("coll_w1c", OFF_PENDING, 32'h00);
        irq_in = '0;
        repeat (3) tick();

        // ------------------------------------------------------ mid-run reset
        bus_write(reg_addr(OFF_ENABLE), 32'h05);
        irq_in = 8'h05;
        repeat (2) tick();
        irq_in = 8'h00;
        repeat (3) tick();
        expect_reg("rst_pre_pending", OFF_PENDING, 32'h05);
        check("rst_pre_irqout", 32'(irq_out), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_irqout", 32'(irq_out), 32'h0);
        expect_reg("rst_pending", OFF_PENDING, 32'h00);
        expect_reg("rst_claim",   OFF_CLAIM,   32'h00);
        #5;
        rst = 1'b1;
        tick();
        expect_reg("rst_post_enable",  OFF_ENABLE,  32'h00);
        expect_reg("rst_post_mode",    OFF_MODE,    32'h00);
        expect_reg("rst_post_pending", OFF_PENDING, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_beta_irq_ctrl
